// File: rtl/rx_link_sync_ctrl.sv
// rtl/rx_link_sync_ctrl.sv - receive-side comma-based link synchronisation controller
//
// Purpose:
//   Sits on the byte stream of the phy_rx deserializer. Counts consecutive
//   comma bytes to bring the lane up, strips commas/idles, forwards data
//   bytes, tolerates isolated code errors through a CHECK state and drops
//   the link (pulsing resync) on repeated errors or a strobe timeout.
//
// Ports:
//   i_clk_4f       in   1  byte-rate clock, rising edge
//   i_reset        in   1  asynchronous active-high reset
//   i_rx_byte      in   8  deserialized byte, qualified by i_rx_strobe
//   i_rx_strobe    in   1  one-cycle byte-present qualifier
//   i_rx_code_err  in   1  code violation on the current byte
//   o_data_out     out  8  last forwarded data byte
//   o_valid_out    out  1  o_data_out carries a new data byte this cycle
//   o_active       out  1  link synchronised (SYNC or CHECK)
//   o_resync       out  1  one-cycle pulse: restart comma alignment
//   o_link_state   out  2  00 LOSS, 01 ACQ, 10 SYNC, 11 CHECK
//   o_drop_count   out  8  SYNC/CHECK -> LOSS drops, saturating at 255

module rx_link_sync_ctrl #(
   parameter logic [7:0] COMMA_BYTE  = 8'hBC,
   parameter int         COMMA_N     = 4,
   parameter int         ERR_N       = 3,
   parameter int         GOOD_N      = 4,
   parameter int         TIMEOUT_CYC = 16
) (
   input  logic       i_clk_4f,
   input  logic       i_reset,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_strobe,
   input  logic       i_rx_code_err,
   output logic [7:0] o_data_out,
   output logic       o_valid_out,
   output logic       o_active,
   output logic       o_resync,
   output logic [1:0] o_link_state,
   output logic [7:0] o_drop_count
);

   localparam logic [1:0] ST_LOSS  = 2'b00;
   localparam logic [1:0] ST_ACQ   = 2'b01;
   localparam logic [1:0] ST_SYNC  = 2'b10;
   localparam logic [1:0] ST_CHECK = 2'b11;

   localparam logic [3:0] L_COMMA_N = 4'(COMMA_N);
   localparam logic [3:0] L_ERR_N   = 4'(ERR_N);
   localparam logic [3:0] L_GOOD_N  = 4'(GOOD_N);
   localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT_CYC);

   // state and registered outputs
   logic [1:0] r_state;
   logic [7:0] r_data_out;
   logic       r_valid_out;
   logic       r_active;
   logic       r_resync;
   logic [7:0] r_drop_count;

   // bring-up / error tracking counters
   logic [3:0] r_comma_cnt;
   logic [3:0] r_err_cnt;
   logic [3:0] r_good_cnt;
   logic [7:0] r_timer;

   // byte classification; a code error overrides a comma match
   logic       w_is_err;
   logic       w_is_comma;
   logic       w_is_data;
   logic       w_link_up;
   logic       w_timeout;
   logic [3:0] w_comma_inc;
   logic [3:0] w_err_inc;
   logic [3:0] w_good_inc;
   logic [7:0] w_timer_inc;

   logic [1:0] w_next_state;
   logic [7:0] w_data_nxt;
   logic       w_valid_nxt;
   logic       w_active_nxt;
   logic       w_resync_nxt;
   logic [7:0] w_drop_nxt;
   logic [3:0] w_comma_nxt;
   logic [3:0] w_err_nxt;
   logic [3:0] w_good_nxt;
   logic [7:0] w_timer_nxt;

   assign w_is_err    = i_rx_strobe &  i_rx_code_err;
   assign w_is_comma  = i_rx_strobe & ~i_rx_code_err & (i_rx_byte == COMMA_BYTE);
   assign w_is_data   = i_rx_strobe & ~i_rx_code_err & (i_rx_byte != COMMA_BYTE);
   assign w_link_up   = (r_state == ST_SYNC) || (r_state == ST_CHECK);
   assign w_comma_inc = r_comma_cnt + 4'd1;
   assign w_err_inc   = r_err_cnt + 4'd1;
   assign w_good_inc  = r_good_cnt + 4'd1;
   assign w_timer_inc = r_timer + 8'd1;

   // A strobe always clears the timer, so a timeout can only fire on a
   // strobe-free cycle and never coincides with a byte event.
   assign w_timeout = (r_state != ST_LOSS) && !i_rx_strobe && (w_timer_inc == L_TIMEOUT);

   // state register
   always_ff @(posedge i_clk_4f or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_LOSS;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_LOSS: begin
            if (w_is_comma) begin
               w_next_state = (COMMA_N == 1) ? ST_SYNC : ST_ACQ;
            end
         end
         ST_ACQ: begin
            if (w_timeout || w_is_data || w_is_err) begin
               w_next_state = ST_LOSS;
            end else if (w_is_comma && (w_comma_inc == L_COMMA_N)) begin
               w_next_state = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (w_timeout) begin
               w_next_state = ST_LOSS;
            end else if (w_is_err) begin
               w_next_state = (ERR_N == 1) ? ST_LOSS : ST_CHECK;
            end
         end
         default: begin  // ST_CHECK
            if (w_timeout) begin
               w_next_state = ST_LOSS;
            end else if (w_is_err) begin
               if (w_err_inc == L_ERR_N) begin
                  w_next_state = ST_LOSS;
               end
            end else if ((w_is_comma || w_is_data) && (w_good_inc == L_GOOD_N)) begin
               w_next_state = ST_SYNC;
            end
         end
      endcase
   end

   // output / counter next-value logic
   always_comb begin
      w_valid_nxt  = 1'b0;
      w_data_nxt   = r_data_out;
      w_active_nxt = (w_next_state == ST_SYNC) || (w_next_state == ST_CHECK);
      // Any exit to LOSS from a non-LOSS state restarts alignment. LOSS is
      // always occupied for at least a cycle, so pulses cannot be adjacent.
      w_resync_nxt = (r_state != ST_LOSS) && (w_next_state == ST_LOSS);
      w_drop_nxt   = r_drop_count;
      w_comma_nxt  = 4'd0;
      w_err_nxt    = 4'd0;
      w_good_nxt   = 4'd0;
      w_timer_nxt  = 8'd0;

      if (w_link_up && w_is_data) begin
         w_valid_nxt = 1'b1;
         w_data_nxt  = i_rx_byte;
      end

      // only a link that was actually up counts as a drop
      if (w_link_up && (w_next_state == ST_LOSS) && (r_drop_count != 8'hFF)) begin
         w_drop_nxt = r_drop_count + 8'd1;
      end

      if (w_next_state == ST_ACQ) begin
         if (r_state == ST_ACQ) begin
            w_comma_nxt = w_is_comma ? w_comma_inc : r_comma_cnt;
         end else begin
            w_comma_nxt = 4'd1;
         end
      end

      if (w_next_state == ST_CHECK) begin
         if (r_state == ST_SYNC) begin
            w_err_nxt  = 4'd1;
            w_good_nxt = 4'd0;
         end else if (w_is_err) begin
            w_err_nxt  = w_err_inc;
            w_good_nxt = 4'd0;
         end else if (w_is_comma || w_is_data) begin
            w_err_nxt  = r_err_cnt;
            w_good_nxt = w_good_inc;
         end else begin
            w_err_nxt  = r_err_cnt;
            w_good_nxt = r_good_cnt;
         end
      end

      // timer runs only while out of LOSS and between strobes
      if ((w_next_state != ST_LOSS) && !i_rx_strobe) begin
         w_timer_nxt = w_timer_inc;
      end
   end

   // registered outputs and counters
   always_ff @(posedge i_clk_4f or posedge i_reset) begin
      if (i_reset) begin
         r_data_out   <= 8'd0;
         r_valid_out  <= 1'b0;
         r_active     <= 1'b0;
         r_resync     <= 1'b0;
         r_drop_count <= 8'd0;
         r_comma_cnt  <= 4'd0;
         r_err_cnt    <= 4'd0;
         r_good_cnt   <= 4'd0;
         r_timer      <= 8'd0;
      end else begin
         r_data_out   <= w_data_nxt;
         r_valid_out  <= w_valid_nxt;
         r_active     <= w_active_nxt;
         r_resync     <= w_resync_nxt;
         r_drop_count <= w_drop_nxt;
         r_comma_cnt  <= w_comma_nxt;
         r_err_cnt    <= w_err_nxt;
         r_good_cnt   <= w_good_nxt;
         r_timer      <= w_timer_nxt;
      end
   end

   assign o_data_out   = r_data_out;
   assign o_valid_out  = r_valid_out;
   assign o_active     = r_active;
   assign o_resync     = r_resync;
   assign o_link_state = r_state;
   assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_rx_link_sync_ctrl.sv
// tb/tb_rx_link_sync_ctrl.sv - self-checking bench for rx_link_sync_ctrl

module tb_rx_link_sync_ctrl;

   localparam int COMMA   = 8'hBC;
   localparam int NCOMMA  = 4;
   localparam int NERR    = 3;
   localparam int NGOOD   = 4;
   localparam int TIMEOUT = 16;

   logic       clk;
   logic       reset;
   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       rx_code_err;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       resync;
   logic [1:0] link_state;
   logic [7:0] drop_count;

   int n_pass;
   int n_total;

   // reference model state: link mode 0 LOSS 1 ACQ 2 SYNC 3 CHECK
   int m_mode;
   int m_commas;
   int m_errs;
   int m_goods;
   int m_idle;
   int m_data;
   int m_valid;
   int m_resync;
   int m_drops;

   rx_link_sync_ctrl dut (
      .i_clk_4f      (clk),
      .i_reset       (reset),
      .i_rx_byte     (rx_byte),
      .i_rx_strobe   (rx_strobe),
      .i_rx_code_err (rx_code_err),
      .o_data_out    (data_out),
      .o_valid_out   (valid_out),
      .o_active      (active),
      .o_resync      (resync),
      .o_link_state  (link_state),
      .o_drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = 0; m_commas = 0; m_errs = 0; m_goods = 0; m_idle = 0;
      m_data = 0; m_valid = 0; m_resync = 0; m_drops = 0;
   endtask

   task automatic model_lose();
      if (m_mode >= 2) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      m_resync = 1;
      m_mode = 0; m_commas = 0; m_errs = 0; m_goods = 0; m_idle = 0;
   endtask

   // one clock of the link rules, applied to the inputs presented this cycle
   task automatic model_step(input int stb, input int b, input int e);
      int kind;  // 0 none, 1 comma, 2 data, 3 error
      m_valid  = 0;
      m_resync = 0;
      if (m_mode == 0 || stb != 0) m_idle = 0;
      else m_idle++;
      if (m_mode != 0 && m_idle >= TIMEOUT) begin
         model_lose();
         return;
      end
      if (stb == 0) kind = 0;
      else if (e != 0) kind = 3;
      else if (b == COMMA) kind = 1;
      else kind = 2;
      if (kind == 0) return;
      if (m_mode == 0) begin
         if (kind == 1) begin
            m_commas = 1;
            m_mode = 1;
            if (m_commas >= NCOMMA) begin m_mode = 2; m_commas = 0; end
         end
      end else if (m_mode == 1) begin
         if (kind == 1) begin
            m_commas++;
            if (m_commas >= NCOMMA) begin m_mode = 2; m_commas = 0; end
         end else begin
            model_lose();
         end
      end else begin
         if (kind == 2) begin
            m_valid = 1;
            m_data  = b;
         end
         if (kind == 3) begin
            m_errs = (m_mode == 2) ? 1 : m_errs + 1;
            m_goods = 0;
            m_mode = 3;
            if (m_errs >= NERR) model_lose();
         end else if (m_mode == 3) begin
            m_goods++;
            if (m_goods >= NGOOD) begin m_mode = 2; m_errs = 0; m_goods = 0; end
         end
      end
   endtask

   task automatic compare_all();
      check("link_state", int'(link_state), m_mode);
      check("active",     int'(active),     (m_mode >= 2) ? 1 : 0);
      check("valid_out",  int'(valid_out),  m_valid);
      check("data_out",   int'(data_out),   m_data);
      check("resync",     int'(resync),     m_resync);
      check("drop_count", int'(drop_count), m_drops);
   endtask

   // present inputs at a falling edge, advance the model, check at the next falling edge
   task automatic cycle(input int stb, input int b, input int e);
      rx_strobe   = (stb != 0);
      rx_byte     = 8'(b);
      rx_code_err = (e != 0);
      model_step(stb, b, e);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx_strobe = 1'b0; rx_byte = 8'h00; rx_code_err = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      compare_all();
      reset = 1'b0;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      reset = 1'b1;
      rx_strobe = 1'b0; rx_byte = 8'h00; rx_code_err = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      check("rst_state",  int'(link_state), 0);
      check("rst_drop",   int'(drop_count), 0);
      check("rst_active", int'(active), 0);

      // bring-up on four commas
      for (int i = 0; i < 4; i++) begin
         cycle(1, COMMA, 0);
         check("bringup_state", int'(link_state), (i < 3) ? 1 : 2);
         check("bringup_valid", int'(valid_out), 0);
      end
      check("bringup_active", int'(active), 1);

      // data forwarding with a comma stripped in between
      cycle(1, 8'h12, 0);
      check("fwd_v0", int'(valid_out), 1);
      check("fwd_d0", int'(data_out), 8'h12);
      cycle(1, COMMA, 0);
      check("fwd_v1", int'(valid_out), 0);
      cycle(1, 8'h34, 0);
      check("fwd_v2", int'(valid_out), 1);
      check("fwd_d2", int'(data_out), 8'h34);
      cycle(0, 0, 0);
      check("fwd_hold", int'(data_out), 8'h34);

      // three code errors with data between: CHECK then LOSS
      cycle(1, 8'h00, 1);
      check("err1_state", int'(link_state), 3);
      cycle(1, 8'h21, 0);
      cycle(1, 8'h00, 1);
      cycle(1, 8'h22, 0);
      cycle(1, 8'h00, 1);
      check("err3_state", int'(link_state), 0);
      check("err3_resync", int'(resync), 1);
      check("err3_drop", int'(drop_count), 1);
      cycle(0, 0, 0);
      check("err3_pulse_end", int'(resync), 0);

      // acquisition aborted by data: resync but no drop
      cycle(1, COMMA, 0);
      cycle(1, COMMA, 0);
      cycle(1, 8'h55, 0);
      check("acq_state", int'(link_state), 0);
      check("acq_resync", int'(resync), 1);
      check("acq_drop", int'(drop_count), 1);
      cycle(0, 0, 0);
      check("acq_pulse_end", int'(resync), 0);

      // single error recovered by four good bytes
      for (int i = 0; i < 4; i++) cycle(1, COMMA, 0);
      cycle(1, 8'h00, 1);
      check("rec_check", int'(link_state), 3);
      cycle(1, 8'h41, 0);
      cycle(1, COMMA, 0);
      cycle(1, 8'h42, 0);
      check("rec_still_check", int'(link_state), 3);
      check("rec_active", int'(active), 1);
      cycle(1, 8'h43, 0);
      check("rec_sync", int'(link_state), 2);
      check("rec_noresync", int'(resync), 0);

      // strobe timeout in SYNC
      for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0);
      check("to_before", int'(link_state), 2);
      cycle(0, 0, 0);
      check("to_state", int'(link_state), 0);
      check("to_resync", int'(resync), 1);
      check("to_drop", int'(drop_count), 2);

      // reset in the middle of SYNC
      for (int i = 0; i < 4; i++) cycle(1, COMMA, 0);
      cycle(1, 8'h77, 0);
      do_reset();
      check("midrst_state", int'(link_state), 0);
      check("midrst_drop", int'(drop_count), 0);
      check("midrst_data", int'(data_out), 0);
      check("midrst_resync", int'(resync), 0);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         int stb, b, e;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 79) == 0) begin
            int gap;
            gap = $urandom_range(8, 24);
            for (int g = 0; g < gap; g++) cycle(0, $urandom_range(0, 255), $urandom_range(0, 1));
         end else begin
            stb = ($urandom_range(0, 9) < 7) ? 1 : 0;
            b   = ($urandom_range(0, 9) < 6) ? COMMA : $urandom_range(0, 255);
            e   = ($urandom_range(0, 99) < 6) ? 1 : 0;
            cycle(stb, b, e);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
